// File: rtl/rider_steer_if.sv
// Purpose : bundles the load-cell sample inputs and steering status outputs of rider_steer_ctrl.
// Latency : n/a (signal container only).
// Backpres: none; ld_vld is a one-cycle qualifier with no ready path.
//
// Signals:
//   ld_vld       sample qualifier, one cycle per sample
//   lft_ld       left load cell, unsigned, LD_W bits
//   rght_ld      right load cell, unsigned, LD_W bits
//   clr_fault    clears the saturation fault (only meaningful with STEER_FAULT_EN)
//   en_steer     steering enable, registered
//   rider_off    one-cycle pulse when a rider leaves (entry to IDLE)
//   ld_cell_diff signed lft - rght of the last captured sample, LD_W+1 bits
//   state_o      controller state: IDLE=0, WAIT=1, STEER=2, FAULT=3
//
// Modports: master drives the samples (producer / bench), slave is the controller.
interface rider_steer_if #(
  parameter int LD_W = 12
);
  logic                 ld_vld;
  logic [LD_W-1:0]      lft_ld;
  logic [LD_W-1:0]      rght_ld;
  logic                 clr_fault;
  logic                 en_steer;
  logic                 rider_off;
  logic signed [LD_W:0] ld_cell_diff;
  logic [1:0]           state_o;

  modport master (
    output ld_vld,
    output lft_ld,
    output rght_ld,
    output clr_fault,
    input  en_steer,
    input  rider_off,
    input  ld_cell_diff,
    input  state_o
  );

  modport slave (
    input  ld_vld,
    input  lft_ld,
    input  rght_ld,
    input  clr_fault,
    output en_steer,
    output rider_off,
    output ld_cell_diff,
    output state_o
  );
endinterface

// File: rtl/rider_steer_ctrl.sv
// Purpose : rider-detection FSM for a self-balancing platform; enables steering once a
//           rider of sufficient weight has stood balanced for a full stability-timer period.
// Latency : sample captured on the ld_vld edge, decided one cycle later; outputs are
//           registered (en_steer trails the state by one cycle).
// Backpres: none; every ld_vld sample is accepted, back-to-back samples give one decision each.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rider_steer_if.slave (ld_vld/lft_ld/rght_ld/clr_fault in;
//          en_steer/rider_off/ld_cell_diff/state_o out)
//
// Optional feature: define STEER_FAULT_EN to add the load-cell saturation fault
// (SAT_CNT consecutive samples with either cell all-ones forces FAULT until clr_fault).
module rider_steer_ctrl #(
  parameter int LD_W       = 12,
  parameter int TMR_W      = 26,
  parameter int FAST_TMR_W = 15,
  parameter int FAST_SIM   = 0,
  parameter int MIN_WT     = 'h200,
  parameter int HYST       = 'h20,
  parameter int ON_SHIFT   = 3,
  parameter int OFF_SHIFT  = 4,
  parameter int SAT_CNT    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rider_steer_if.slave  bus
);

  localparam int TW = (FAST_SIM != 0) ? FAST_TMR_W : TMR_W;

  // Weight thresholds with hysteresis, sized to the sum so comparisons stay width-clean.
  localparam logic [LD_W:0] WT_ON  = (LD_W+1)'(MIN_WT + HYST);
  localparam logic [LD_W:0] WT_OFF = (LD_W+1)'(MIN_WT - HYST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // ------------------------------------------------------------------
  // Sample capture
  // ------------------------------------------------------------------
  logic [LD_W-1:0]      lft_q;
  logic [LD_W-1:0]      rght_q;
  logic                 smp_vld;
  logic signed [LD_W:0] ld_cell_diff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q          <= '0;
      rght_q         <= '0;
      smp_vld        <= 1'b0;
      ld_cell_diff_q <= '0;
    end else begin
      smp_vld <= bus.ld_vld;
      if (bus.ld_vld) begin
        lft_q          <= bus.lft_ld;
        rght_q         <= bus.rght_ld;
        ld_cell_diff_q <= $signed({1'b0, bus.lft_ld}) - $signed({1'b0, bus.rght_ld});
      end
    end
  end

  // ------------------------------------------------------------------
  // Weight / balance comparators on the captured sample
  // ------------------------------------------------------------------
  logic [LD_W:0]   sum;
  logic [LD_W-1:0] diff;
  logic [LD_W:0]   diff_x;
  logic            gt_min;
  logic            lt_min;
  logic            unstbl_on;
  logic            unstbl_off;

  assign sum    = {1'b0, lft_q} + {1'b0, rght_q};
  assign diff   = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
  assign diff_x = {1'b0, diff};

  assign gt_min     = sum > WT_ON;
  assign lt_min     = sum < WT_OFF;
  // Entering STEER needs tight balance; staying in STEER tolerates a much larger skew,
  // so a rider shifting weight while turning does not drop out.
  assign unstbl_on  = diff_x > (sum >> ON_SHIFT);
  assign unstbl_off = diff_x > (sum - (sum >> OFF_SHIFT));

  // ------------------------------------------------------------------
  // Stability timer
  // ------------------------------------------------------------------
  logic [TW-1:0] tmr;
  logic          tmr_full;
  logic          tmr_clr;

  assign tmr_full = &tmr;

  // ------------------------------------------------------------------
  // Saturation fault
  // ------------------------------------------------------------------
  logic fault_trip;
  logic fault_clr;

`ifdef STEER_FAULT_EN
  localparam int              SAT_W   = $clog2(SAT_CNT + 1);
  localparam logic [SAT_W-1:0] SAT_LIM = SAT_W'(SAT_CNT);

  logic [SAT_W-1:0] sat_cnt;
  logic [SAT_W-1:0] sat_inc;
  logic             cell_sat;

  assign cell_sat = (&lft_q) | (&rght_q);

  // Count consecutive saturated samples; the count sticks at the limit so a
  // permanently railed cell keeps re-asserting the trip on every sample.
  always_comb begin
    sat_inc = sat_cnt;
    if (smp_vld) begin
      if (cell_sat) begin
        sat_inc = (sat_cnt == SAT_LIM) ? sat_cnt : sat_cnt + SAT_W'(1);
      end else begin
        sat_inc = '0;
      end
    end
  end

  assign fault_trip = smp_vld && (sat_inc == SAT_LIM);
  // A clear is not gated by smp_vld so a lone clr_fault pulse is never lost,
  // but a trip in the same cycle wins and keeps the block in FAULT.
  assign fault_clr  = (state == FAULT) && bus.clr_fault && !fault_trip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (fault_clr) begin
      sat_cnt <= '0;
    end else begin
      sat_cnt <= sat_inc;
    end
  end
`else
  logic unused_fault_cfg;

  assign fault_trip       = 1'b0;
  assign fault_clr        = 1'b0;
  assign unused_fault_cfg = bus.clr_fault ^ SAT_CNT[0];
`endif

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Weight/balance decisions are only taken on a fresh sample; the timer expiry
  // in WAIT is the one transition that can fire between samples.
  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    if (fault_trip) begin
      state_nxt = FAULT;
    end else begin
      case (state)
        IDLE: begin
          if (smp_vld && gt_min) begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (smp_vld && !gt_min) begin
            state_nxt = IDLE;
          end else if (smp_vld && unstbl_on) begin
            tmr_clr = 1'b1;
          end else if (tmr_full) begin
            state_nxt = STEER;
          end
        end
        STEER: begin
          if (smp_vld) begin
            if (lt_min) begin
              state_nxt = IDLE;
            end else if (unstbl_off) begin
              state_nxt = WAIT;
            end
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Timer only runs while staying in WAIT; any entry to WAIT or imbalance restarts
  // it from zero, and it parks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if ((state == WAIT) && (state_nxt == WAIT) && !tmr_clr) begin
      tmr <= tmr_full ? tmr : tmr + TW'(1);
    end else begin
      tmr <= '0;
    end
  end

  // ------------------------------------------------------------------
  // Registered outputs
  // ------------------------------------------------------------------
  logic en_steer_q;
  logic rider_off_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b0;
    end else begin
      en_steer_q  <= (state == STEER);
      // Fires together with the IDLE entry; FAULT->IDLE and reset are excluded.
      rider_off_q <= (state_nxt == IDLE) && ((state == WAIT) || (state == STEER));
    end
  end

  assign bus.en_steer     = en_steer_q;
  assign bus.rider_off    = rider_off_q;
  assign bus.ld_cell_diff = ld_cell_diff_q;
  assign bus.state_o      = state;

`ifndef SYNTHESIS
  // IDLE is entered at most once per cycle pair, so the pulse can never stretch.
  a_off_single: assert property (@(posedge clk) disable iff (!rst_n)
    rider_off_q |=> !rider_off_q);

  // The timer is only ever non-zero while waiting for stability.
  a_tmr_wait_only: assert property (@(posedge clk) disable iff (!rst_n)
    (tmr != '0) |-> (state == WAIT));
`endif

endmodule

// File: tb/tb_rider_steer_ctrl.sv
module tb_rider_steer_ctrl;

  localparam int LD_W      = 12;
  localparam int FTW       = 12;
  localparam int MIN_WT    = 'h200;
  localparam int HYST      = 'h20;
  localparam int ON_SHIFT  = 3;
  localparam int OFF_SHIFT = 4;
  localparam int SAT_CNT   = 8;
  localparam int MAXV      = (1 << LD_W) - 1;
  localparam int FULL      = (1 << FTW) - 1;
`ifdef STEER_FAULT_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rider_steer_if #(.LD_W(LD_W)) bus_if ();

  rider_steer_ctrl #(
    .LD_W       (LD_W),
    .TMR_W      (26),
    .FAST_TMR_W (FTW),
    .FAST_SIM   (1),
    .MIN_WT     (MIN_WT),
    .HYST       (HYST),
    .ON_SHIFT   (ON_SHIFT),
    .OFF_SHIFT  (OFF_SHIFT),
    .SAT_CNT    (SAT_CNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: state decisions from the rules, timer kept as a
  // timestamp of the cycle where the stability period last (re)started.
  // ------------------------------------------------------------------
  int m_lft   = 0;
  int m_rght  = 0;
  int m_diff  = 0;
  int m_state = 0;
  int m_since = 0;
  int m_sat   = 0;
  int cyc     = 0;
  bit m_vld   = 1'b0;
  bit m_en    = 1'b0;
  bit m_off   = 1'b0;

  task automatic model_step();
    int sum, d, nxt, nsat;
    bit gt, lt, uon, uoff, full, trip, restart;
    sum  = m_lft + m_rght;
    d    = (m_lft > m_rght) ? m_lft - m_rght : m_rght - m_lft;
    gt   = sum > MIN_WT + HYST;
    lt   = sum < MIN_WT - HYST;
    uon  = d > (sum >> ON_SHIFT);
    uoff = d > sum - (sum >> OFF_SHIFT);
    full = (cyc - m_since) >= FULL;
    nsat = m_sat;
    trip = 1'b0;
    if (FE && m_vld) begin
      if (m_lft == MAXV || m_rght == MAXV) nsat = (m_sat < SAT_CNT) ? m_sat + 1 : SAT_CNT;
      else nsat = 0;
      trip = (nsat == SAT_CNT);
    end
    nxt     = m_state;
    restart = 1'b0;
    if (trip) begin
      nxt = 3;
    end else begin
      case (m_state)
        0: if (m_vld && gt) nxt = 1;
        1: begin
          if (m_vld && !gt) nxt = 0;
          else if (m_vld && uon) restart = 1'b1;
          else if (full) nxt = 2;
        end
        2: begin
          if (m_vld && lt) nxt = 0;
          else if (m_vld && uoff) nxt = 1;
        end
        default: begin
          if (bus_if.clr_fault) begin
            nxt  = 0;
            nsat = 0;
          end
        end
      endcase
    end
    if (nxt == 1 && m_state != 1) restart = 1'b1;
    if (restart) m_since = cyc + 1;
    m_en  = (m_state == 2);
    m_off = (nxt == 0) && (m_state == 1 || m_state == 2);
    m_sat = nsat;
    m_vld = bus_if.ld_vld;
    if (bus_if.ld_vld) begin
      m_lft  = int'(bus_if.lft_ld);
      m_rght = int'(bus_if.rght_ld);
      m_diff = m_lft - m_rght;
    end
    m_state = nxt;
    cyc++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lft   = 0;
      m_rght  = 0;
      m_diff  = 0;
      m_state = 0;
      m_sat   = 0;
      m_vld   = 1'b0;
      m_en    = 1'b0;
      m_off   = 1'b0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("state", bus_if.state_o, m_state);
    chk("en_steer", bus_if.en_steer, m_en);
    chk("rider_off", bus_if.rider_off, m_off);
    chk("ld_cell_diff", bus_if.ld_cell_diff, m_diff);
  end

  // ------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge only.
  // ------------------------------------------------------------------
  task automatic tick(input bit v, input int l, input int r, input bit c);
    @(negedge clk);
    bus_if.ld_vld    = v;
    bus_if.lft_ld    = l[LD_W-1:0];
    bus_if.rght_ld   = r[LD_W-1:0];
    bus_if.clr_fault = c;
  endtask

  task automatic run_until(input int st, input int l, input int r, input int lim,
                           output int n);
    n = 0;
    do begin
      tick(1'b1, l, r, 1'b0);
      n++;
    end while (bus_if.state_o != st[1:0] && n < lim);
  endtask

  initial begin
    int n, ones, hold, l, r, k;
    bus_if.ld_vld    = 1'b0;
    bus_if.lft_ld    = '0;
    bus_if.rght_ld   = '0;
    bus_if.clr_fault = 1'b0;
    rst_n            = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_state", bus_if.state_o, 0);
    chk("rst_en_steer", bus_if.en_steer, 0);
    chk("rst_rider_off", bus_if.rider_off, 0);
    chk("rst_diff", bus_if.ld_cell_diff, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Balanced heavy rider: WAIT, then STEER after exactly 2^FTW cycles of WAIT.
    run_until(1, 'h120, 'h120, 20, n);
    chk("idle_to_wait", bus_if.state_o, 1);
    run_until(2, 'h120, 'h120, FULL + 50, n);
    chk("wait_to_steer_cycles", n, FULL + 1);
    chk("en_steer_lags_entry", bus_if.en_steer, 0);
    tick(1'b1, 'h120, 'h120, 1'b0);
    chk("en_steer_in_steer", bus_if.en_steer, 1);

    // Sum 0x1F0 sits inside the hysteresis band: stays in STEER.
    repeat (6) tick(1'b1, 'h0F8, 'h0F8, 1'b0);
    chk("band_stays_steer", bus_if.state_o, 2);
    // Heavy skew leaves STEER for WAIT; the follow-up skewed samples keep clearing the timer.
    tick(1'b1, 'h1F0, 'h000, 1'b0);
    tick(1'b1, 'h200, 'h080, 1'b0);
    chk("skew_diff", bus_if.ld_cell_diff, 'h1F0);
    tick(1'b1, 'h200, 'h080, 1'b0);
    chk("steer_to_wait", bus_if.state_o, 1);
    chk("diff_180", bus_if.ld_cell_diff, 'h180);
    repeat (8) tick(1'b1, 'h200, 'h080, 1'b0);
    chk("unstable_holds_wait", bus_if.state_o, 1);
    // The skewed sample still in flight clears once more, then a full period is needed.
    run_until(2, 'h120, 'h120, FULL + 50, n);
    chk("restart_full_count", n, FULL + 3);

    // Rider steps down below MIN_WT-HYST.
    tick(1'b1, 'h0E0, 'h0E0, 1'b0);
    tick(1'b1, 'h0E0, 'h0E0, 1'b0);
    chk("drop_not_yet", bus_if.state_o, 2);
    chk("drop_no_off_yet", bus_if.rider_off, 0);
    tick(1'b1, 'h0E0, 'h0E0, 1'b0);
    chk("drop_to_idle", bus_if.state_o, 0);
    chk("rider_off_pulse", bus_if.rider_off, 1);
    chk("en_steer_trails", bus_if.en_steer, 1);
    tick(1'b1, 'h0E0, 'h0E0, 1'b0);
    chk("rider_off_single", bus_if.rider_off, 0);
    chk("en_steer_dropped", bus_if.en_steer, 0);
    ones = 0;
    repeat (5) begin
      tick(1'b1, 'h0E0, 'h0E0, 1'b0);
      ones += int'(bus_if.rider_off);
    end
    chk("no_off_in_idle", ones, 0);

    // Right cell heavier gives a negative difference.
    tick(1'b1, 'h010, 'h300, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    chk("negative_diff", bus_if.ld_cell_diff, -752);

    // Asynchronous reset in the middle of STEER.
    run_until(2, 'h120, 'h120, FULL + 50, n);
    chk("reach_steer_again", bus_if.state_o, 2);
    tick(1'b1, 'h120, 'h120, 1'b0);
    tick(1'b1, 'h120, 'h120, 1'b0);
    chk("en_before_reset", bus_if.en_steer, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en_drop", bus_if.en_steer, 0);
    chk("async_state_idle", bus_if.state_o, 0);
    chk("async_no_off", bus_if.rider_off, 0);
    tick(1'b0, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    ones = 0;
    repeat (6) begin
      tick(1'b1, 'h120, 'h120, 1'b0);
      ones += int'(bus_if.rider_off);
    end
    chk("no_off_after_reset", ones, 0);

`ifdef STEER_FAULT_EN
    repeat (8) tick(1'b1, MAXV, 0, 1'b0);
    run_until(3, 'h120, 'h120, 6, n);
    chk("sat_fault", bus_if.state_o, 3);
    chk("fault_en_low", bus_if.en_steer, 0);
    tick(1'b1, 'h120, 'h120, 1'b1);
    tick(1'b1, 'h120, 'h120, 1'b0);
    chk("clr_to_idle", bus_if.state_o, 0);
    chk("clr_no_off", bus_if.rider_off, 0);
`else
    ones = 0;
    repeat (12) begin
      tick(1'b1, MAXV, 0, 1'b1);
      if (bus_if.state_o == 2'd3) ones++;
    end
    chk("no_fault_state", ones, 0);
`endif

    // Randomized phase: long steady stretches reach STEER, chaotic stretches exercise exits.
    for (int seg = 0; seg < 6; seg++) begin
      hold = int'($urandom_range('h7FF, 'h118));
      if (seg % 2 == 0) begin
        for (int i = 0; i < FULL + 300; i++) begin
          r = hold - int'($urandom_range(hold >> 4, 0));
          tick($urandom_range(3, 0) != 0, hold, r, 1'b0);
        end
      end else begin
        for (int i = 0; i < 1500; i++) begin
          k = int'($urandom_range(15, 0));
          if (k == 0) begin
            l = MAXV;
            r = int'($urandom_range(MAXV, 0));
          end else if (k < 5) begin
            l = int'($urandom_range('h118, 'h0E8));
            r = int'($urandom_range('h118, 'h0E8));
          end else if (k < 9) begin
            l = int'($urandom_range(MAXV, 0));
            r = int'($urandom_range(MAXV, 0));
          end else begin
            l = hold;
            r = hold - int'($urandom_range(hold >> 3, 0));
          end
          tick($urandom_range(2, 0) != 0, l, r, $urandom_range(31, 0) == 0);
        end
      end
    end

    tick(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rider_steer_ctrl.md
RIDER_STEER_CTRL -- requirements
Module: rider_steer_ctrl

Interface
REQ-001 Parameter LD_W, default 12: load-cell width in bits.
REQ-002 Parameter TMR_W, default 26: stability-timer width in bits.
REQ-003 Parameter FAST_TMR_W, default 15: timer width used when FAST_SIM=1.
REQ-004 Parameter FAST_SIM, default 0: selects FAST_TMR_W over TMR_W.
REQ-005 Parameter MIN_WT, default 'h200: minimum rider weight (sum units).
REQ-006 Parameter HYST, default 'h20: weight hysteresis.
REQ-007 Parameter ON_SHIFT, default 3: stable when diff <= sum>>ON_SHIFT.
REQ-008 Parameter OFF_SHIFT, default 4: unstable when diff > sum-(sum>>OFF_SHIFT).
REQ-009 Parameter SAT_CNT, default 8: consecutive saturated samples that raise a fault.
REQ-010 clk  in  1  clock; all logic on rising edge.
REQ-011 rst_n  in  1  reset, asynchronous, active-low.
REQ-012 ld_vld  in  1  qualifies lft_ld/rght_ld for one cycle.
REQ-013 lft_ld  in  LD_W  left load cell, unsigned.
REQ-014 rght_ld  in  LD_W  right load cell, unsigned.
REQ-015 clr_fault  in  1  clears FAULT state (ignored when fault feature compiled out).
REQ-016 en_steer  out  1  registered; high only in STEER.
REQ-017 rider_off  out  1  registered one-cycle pulse on entry to IDLE from WAIT or STEER.
REQ-018 ld_cell_diff  out  LD_W+1  registered signed lft-rght of last valid sample.
REQ-019 state_o  out  2  current state: IDLE=0, WAIT=1, STEER=2, FAULT=3.

Function
REQ-020 Samples SHALL be captured into lft_q/rght_q only when ld_vld=1; smp_vld = ld_vld delayed one cycle.
REQ-021 sum = lft_q+rght_q, LD_W+1 bits, no overflow; diff = |lft_q-rght_q|, LD_W bits; ld_cell_diff updates with lft_q/rght_q.
REQ-022 Comparators: gt_min = sum > MIN_WT+HYST; lt_min = sum < MIN_WT-HYST; unstbl_on = diff > (sum>>ON_SHIFT); unstbl_off = diff > sum-(sum>>OFF_SHIFT); all strict.
REQ-023 FSM SHALL transition only on cycles with smp_vld=1, except timer-driven WAIT->STEER, which may occur on any cycle.
REQ-024 IDLE: gt_min -> WAIT, timer cleared; else stay.
REQ-025 WAIT, priority order: !gt_min -> IDLE; unstbl_on -> stay, timer cleared; tmr_full -> STEER; else stay.
REQ-026 STEER, priority order: lt_min -> IDLE; unstbl_off -> WAIT, timer cleared; else stay.
REQ-027 Timer SHALL increment every cycle in WAIT, hold at zero in other states, and never wrap; tmr_full = all low TW bits set (TW = FAST_SIM?FAST_TMR_W:TMR_W).
REQ-028 en_steer SHALL assert the cycle after state enters STEER and deassert the cycle after it leaves.
REQ-029 rider_off SHALL pulse exactly one cycle per entry to IDLE; it SHALL NOT assert while remaining in IDLE or after reset.
REQ-030 Back-to-back ld_vld SHALL be supported with one decision per sample.

Reset
REQ-031 On rst_n low: state=IDLE, timer=0, lft_q=rght_q=0, smp_vld=0, en_steer=0, rider_off=0, ld_cell_diff=0, sat counter=0.
REQ-032 Reset mid-STEER or mid-WAIT SHALL drop en_steer immediately (asynchronously) and SHALL NOT produce a rider_off pulse.

Configuration
REQ-033 With STEER_FAULT_EN defined: on each smp_vld, a counter increments if lft_q or rght_q is all-ones, else clears; at SAT_CNT, state -> FAULT from any state (highest priority).
REQ-034 FAULT: en_steer=0, rider_off=0, timer held; clr_fault=1 -> IDLE with sat counter cleared, no rider_off pulse.
REQ-035 Without STEER_FAULT_EN: no sat counter, FAULT unreachable, clr_fault unused, state_o never 3.

Verification
REQ-036 FAST_SIM=1; lft=rght='h120 (sum 'h240) held with ld_vld every cycle -> WAIT, then STEER after 2^15 cycles; en_steer high next cycle.
REQ-037 In WAIT, lft='h200 rght='h080 (diff 'h180 > 'h280>>3) -> timer cleared, state stays WAIT; restoring balance restarts full count.
REQ-038 In STEER, drop to lft=rght='h0E0 (sum 'h1C0 < 'h1E0) -> IDLE, rider_off exactly one cycle, en_steer low next cycle.
REQ-039 In STEER, sum 'h1F0 (inside hysteresis band) -> stays STEER; lft='h1F0 rght=0 -> WAIT.
REQ-040 STEER_FAULT_EN: lft='hFFF for 8 valid samples -> FAULT, en_steer 0; clr_fault pulse -> IDLE with no rider_off.
REQ-041 Assert rst_n low mid-STEER -> en_steer 0 immediately, state_o 0, no rider_off after release.
